// File: rtl/obstacle_lane_scroller.sv
// Four-lane obstacle field: spawns, scrolls per frame, scores retirements and detects player collision.
// Optional build macro SPEEDUP_EN: raise scroll speed every SPEEDUP_EVERY passed obstacles.
module obstacle_lane_scroller #(
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned OBS_H         = 40,
  parameter int unsigned PLAYER_Y      = 400,
  parameter int unsigned PLAYER_H      = 40,
  parameter int unsigned SPEED_INIT    = 2,
  parameter int unsigned SPEED_MAX     = 8,
  parameter int unsigned SPEEDUP_EVERY = 8
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        start,
  input  logic        spawn,
  input  logic        check1,
  input  logic        check2,
  input  logic        check3,
  input  logic        check4,
  input  logic [8:0]  position,
  input  logic        frame_tick,
  input  logic [1:0]  player_lane,
  output logic [3:0]  obs_active,
  output logic [35:0] obs_x,
  output logic [39:0] obs_y,
  output logic        hit,
  output logic        spawn_drop,
  output logic [9:0]  score,
  output logic        playing
);

  localparam int unsigned SW = $clog2(SPEED_MAX + 1);
  localparam logic [SW-1:0] SPEED_INIT_W = SW'(SPEED_INIT);
  localparam logic [10:0]   SCREEN_LIM   = 11'(SCREEN_H);
  localparam logic [10:0]   OBS_H_W      = 11'(OBS_H);
  localparam logic [10:0]   PLAYER_TOP   = 11'(PLAYER_Y);
  localparam logic [10:0]   PLAYER_BOT   = 11'(PLAYER_Y + PLAYER_H);
  localparam logic [10:0]   SCORE_MAX    = 11'd999;

  if (SPEEDUP_EVERY == 0 || SPEED_MAX < SPEED_INIT) begin : g_cfg_check
    $error("obstacle_lane_scroller: invalid speed configuration");
  end

  typedef enum logic [1:0] {IDLE, PLAY, HIT} state_t;

  state_t        state;
  logic [9:0]    y_q [4];
  logic [8:0]    x_q [4];
  logic [SW-1:0] speed;

  logic [3:0]    lane_sel;
  logic          one_hot;
  logic [1:0]    lane;
  logic          collide;
  logic [10:0]   sum [4];
  logic [3:0]    retire;
  logic [2:0]    n_retire;
  logic [10:0]   score_sum;
  logic [9:0]    score_next;

  always_comb begin
    lane_sel = ~{check4, check3, check2, check1};
    one_hot  = $onehot(lane_sel);
    lane     = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_sel[i]) lane = 2'(i);
    end

    collide = obs_active[player_lane]
              && ({1'b0, y_q[player_lane]} + OBS_H_W > PLAYER_TOP)
              && ({1'b0, y_q[player_lane]} < PLAYER_BOT);

    n_retire = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]    = {1'b0, y_q[i]} + 11'(speed);
      retire[i] = obs_active[i] && (sum[i] >= SCREEN_LIM);
      n_retire  = n_retire + 3'(retire[i]);
    end

    score_sum  = {1'b0, score} + 11'(n_retire);
    score_next = (score_sum > SCORE_MAX) ? SCORE_MAX[9:0] : score_sum[9:0];
  end

  always_comb begin
    obs_x = '0;
    obs_y = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      obs_x[9*i +: 9]   = x_q[i];
      obs_y[10*i +: 10] = y_q[i];
    end
  end

`ifdef SPEEDUP_EN
  localparam int unsigned PW = $clog2(SPEEDUP_EVERY + 4);
  localparam logic [PW-1:0] EVERY_W     = PW'(SPEEDUP_EVERY);
  localparam logic [SW-1:0] SPEED_MAX_W = SW'(SPEED_MAX);

  logic [PW-1:0] pass_cnt;
  logic [PW-1:0] pass_sum;

  always_comb pass_sum = pass_cnt + PW'(n_retire);
`endif

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state      <= IDLE;
      playing    <= 1'b0;
      obs_active <= '0;
      score      <= '0;
      speed      <= SPEED_INIT_W;
      hit        <= 1'b0;
      spawn_drop <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        y_q[i] <= '0;
        x_q[i] <= '0;
      end
`ifdef SPEEDUP_EN
      pass_cnt <= '0;
`endif
    end else begin
      hit        <= 1'b0;
      spawn_drop <= 1'b0;
      case (state)
        IDLE, HIT: begin
          if (start) begin
            state      <= PLAY;
            playing    <= 1'b1;
            obs_active <= '0;
            score      <= '0;
            speed      <= SPEED_INIT_W;
            for (int unsigned i = 0; i < 4; i++) y_q[i] <= '0;
`ifdef SPEEDUP_EN
            pass_cnt <= '0;
`endif
          end
        end
        PLAY: begin
          if (collide) begin
            state   <= HIT;
            playing <= 1'b0;
            hit     <= 1'b1;
          end else begin
            if (frame_tick) begin
              for (int unsigned i = 0; i < 4; i++) begin
                if (retire[i]) begin
                  obs_active[i] <= 1'b0;
                  y_q[i]        <= '0;
                end else if (obs_active[i]) begin
                  y_q[i] <= sum[i][9:0];
                end
              end
              score <= score_next;
`ifdef SPEEDUP_EN
              if (pass_sum >= EVERY_W) begin
                pass_cnt <= pass_sum - EVERY_W;
                if (speed < SPEED_MAX_W) speed <= speed + 1'b1;
              end else begin
                pass_cnt <= pass_sum;
              end
`endif
            end
            // Occupancy uses pre-tick flags, so a lane retiring this cycle still rejects a spawn.
            if (spawn) begin
              if (one_hot && !obs_active[lane]) begin
                obs_active[lane] <= 1'b1;
                y_q[lane]        <= '0;
                x_q[lane]        <= position;
              end else begin
                spawn_drop <= 1'b1;
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_lane_scroller.sv
// Scoreboard bench: stimulus queues expected per-cycle field values, a negedge monitor compares them.
module tb_obstacle_lane_scroller;

  logic        ck = 1'b0;
  logic        rst_n, start, spawn, check1, check2, check3, check4, frame_tick;
  logic [8:0]  position;
  logic [1:0]  player_lane;
  logic [3:0]  obs_active;
  logic [35:0] obs_x;
  logic [39:0] obs_y;
  logic        hit, spawn_drop, playing;
  logic [9:0]  score;

  obstacle_lane_scroller dut (
    .ck(ck), .rst_n(rst_n), .start(start), .spawn(spawn),
    .check1(check1), .check2(check2), .check3(check3), .check4(check4),
    .position(position), .frame_tick(frame_tick), .player_lane(player_lane),
    .obs_active(obs_active), .obs_x(obs_x), .obs_y(obs_y), .hit(hit),
    .spawn_drop(spawn_drop), .score(score), .playing(playing)
  );

  always #5 ck = ~ck;

  localparam int K_ACT = 0, K_Y = 1, K_X = 2, K_HIT = 3, K_DROP = 4, K_SCORE = 5, K_PLAY = 6;

  typedef struct {
    int cyc;
    int kind;
    int idx;
    int val;
    int step;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   step = 0;
  int   checks = 0;
  int   failures = 0;
  int   act;

  always @(posedge ck) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_ACT:   return "obs_active";
      K_Y:     return "obs_y";
      K_X:     return "obs_x";
      K_HIT:   return "hit";
      K_DROP:  return "spawn_drop";
      K_SCORE: return "score";
      default: return "playing";
    endcase
  endfunction

  always @(negedge ck) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      case (mon_e.kind)
        K_ACT:   act = int'(obs_active);
        K_Y:     act = int'(obs_y[mon_e.idx*10 +: 10]);
        K_X:     act = int'(obs_x[mon_e.idx*9 +: 9]);
        K_HIT:   act = int'(hit);
        K_DROP:  act = int'(spawn_drop);
        K_SCORE: act = int'(score);
        default: act = int'(playing);
      endcase
      checks++;
      if (mon_e.cyc != cyc || act != mon_e.val) begin
        failures++;
        $display("FAIL %s[%0d] step=%0d cyc=%0d got=%0d want=%0d",
                 kname(mon_e.kind), mon_e.idx, mon_e.step, cyc, act, mon_e.val);
      end
    end
  end

  task automatic ex(input int kind, input int idx, input int val);
    exp_t e;
    e.cyc = cyc + 1; e.kind = kind; e.idx = idx; e.val = val; e.step = step;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(negedge ck);
    start = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
    {check4, check3, check2, check1} = 4'b1111;
    step++;
  endtask

  task automatic do_spawn(input logic [3:0] low_mask, input int pos);
    spawn = 1'b1;
    {check4, check3, check2, check1} = ~low_mask;
    position = 9'(pos);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
    {check4, check3, check2, check1} = 4'b1111;
    position = '0; player_lane = 2'd3;
    @(negedge ck);

    // reset state
    ex(K_ACT, 0, 0); ex(K_SCORE, 0, 0); ex(K_PLAY, 0, 0); ex(K_HIT, 0, 0);
    ex(K_DROP, 0, 0); ex(K_Y, 0, 0); ex(K_X, 2, 0);
    cycle();

    rst_n = 1'b1; start = 1'b1;
    ex(K_PLAY, 0, 1); ex(K_ACT, 0, 0);
    cycle();

    do_spawn(4'b0100, 250);
    ex(K_ACT, 0, 4'b0100); ex(K_Y, 2, 0); ex(K_X, 2, 250); ex(K_PLAY, 0, 1); ex(K_DROP, 0, 0);
    cycle();

    do_spawn(4'b0001, 17);
    ex(K_ACT, 0, 4'b0101); ex(K_X, 0, 17);
    cycle();

    // scroll lanes 0 and 2 to the bottom; both retire on tick 240
    for (int k = 1; k <= 240; k++) begin
      frame_tick = 1'b1;
      if (k == 1)   ex(K_Y, 0, 2);
      if (k == 100) ex(K_Y, 0, 200);
      if (k == 239) begin ex(K_Y, 0, 478); ex(K_Y, 2, 478); ex(K_ACT, 0, 4'b0101); ex(K_SCORE, 0, 0); end
      if (k == 240) begin ex(K_ACT, 0, 0); ex(K_SCORE, 0, 2); ex(K_Y, 0, 0); end
      cycle();
    end

    // spawn rejection cases
    do_spawn(4'b0010, 100);
    ex(K_ACT, 0, 4'b0010); ex(K_DROP, 0, 0);
    cycle();
    do_spawn(4'b0010, 50);
    ex(K_DROP, 0, 1); ex(K_ACT, 0, 4'b0010); ex(K_X, 1, 100);
    cycle();
    ex(K_DROP, 0, 0);
    cycle();
    do_spawn(4'b0011, 60);
    ex(K_DROP, 0, 1); ex(K_ACT, 0, 4'b0010);
    cycle();
    do_spawn(4'b0000, 60);
    ex(K_DROP, 0, 1);
    cycle();

    // collision in lane 1 at y=362
    player_lane = 2'd1;
    for (int k = 1; k <= 181; k++) begin
      frame_tick = 1'b1;
      if (k == 180) begin ex(K_Y, 1, 360); ex(K_HIT, 0, 0); end
      if (k == 181) begin ex(K_Y, 1, 362); ex(K_PLAY, 0, 1); ex(K_HIT, 0, 0); end
      cycle();
    end
    frame_tick = 1'b1;
    ex(K_HIT, 0, 1); ex(K_PLAY, 0, 0); ex(K_Y, 1, 362);
    cycle();
    frame_tick = 1'b1;
    ex(K_HIT, 0, 0); ex(K_Y, 1, 362); ex(K_SCORE, 0, 2);
    cycle();
    do_spawn(4'b0001, 33);
    ex(K_DROP, 0, 0); ex(K_ACT, 0, 4'b0010);
    cycle();
    start = 1'b1;
    ex(K_ACT, 0, 0); ex(K_Y, 1, 0); ex(K_SCORE, 0, 0); ex(K_PLAY, 0, 1);
    cycle();

    // spawn and tick together
    player_lane = 2'd0;
    do_spawn(4'b0100, 300);
    ex(K_ACT, 0, 4'b0100); ex(K_X, 2, 300);
    cycle();
    for (int k = 1; k <= 50; k++) begin
      frame_tick = 1'b1;
      if (k == 50) ex(K_Y, 2, 100);
      cycle();
    end
    frame_tick = 1'b1;
    do_spawn(4'b1000, 5);
    ex(K_Y, 2, 102); ex(K_Y, 3, 0); ex(K_X, 3, 5); ex(K_ACT, 0, 4'b1100); ex(K_DROP, 0, 0);
    cycle();
    for (int k = 1; k <= 188; k++) begin
      frame_tick = 1'b1;
      if (k == 188) begin ex(K_Y, 2, 478); ex(K_Y, 3, 376); end
      cycle();
    end
    frame_tick = 1'b1;
    do_spawn(4'b0100, 77);
    ex(K_DROP, 0, 1); ex(K_ACT, 0, 4'b1000); ex(K_Y, 3, 378); ex(K_Y, 2, 0);
    ex(K_SCORE, 0, 1); ex(K_X, 2, 300);
    cycle();

    // reset mid-PLAY overrides start and spawn
    rst_n = 1'b0; start = 1'b1;
    do_spawn(4'b0001, 99);
    ex(K_ACT, 0, 0); ex(K_PLAY, 0, 0); ex(K_SCORE, 0, 0); ex(K_Y, 3, 0);
    ex(K_X, 3, 0); ex(K_X, 2, 0); ex(K_HIT, 0, 0); ex(K_DROP, 0, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();

    checks++;
    if (obs_active !== 4'b0000) begin
      failures++;
      $display("FAIL obs_active[0] step=%0d got=%0d want=0", step, obs_active);
    end
    checks++;
    if (playing !== 1'b0) begin
      failures++;
      $display("FAIL playing[0] step=%0d got=%0d want=0", step, playing);
    end
    checks++;
    if (score !== 10'd0) begin
      failures++;
      $display("FAIL score[0] step=%0d got=%0d want=0", step, score);
    end
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("FAIL hit[0] step=%0d got=%0d want=0", step, hit);
    end
    checks++;
    if (spawn_drop !== 1'b0) begin
      failures++;
      $display("FAIL spawn_drop[0] step=%0d got=%0d want=0", step, spawn_drop);
    end
    checks++;
    if (obs_y !== 40'd0) begin
      failures++;
      $display("FAIL obs_y[0] step=%0d got=%0d want=0", step, obs_y);
    end

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      failures++;
      $display("FAIL %s[%0d] step=%0d got=unchecked want=%0d",
               kname(mon_e.kind), mon_e.idx, mon_e.step, mon_e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
